// File: rtl/avr_cpu_pkg.sv
// avr_cpu_pkg: opcode match patterns, FSM/class encodings and offset widths shared by the flow sequencer
package avr_cpu_pkg;
  typedef enum logic [1:0] {S_EXEC, S_FLUSH, S_LPM_WAIT, S_LPM_WB} state_e;
  typedef enum logic [2:0] {C_NONE, C_RJMP, C_RCALL, C_RET, C_BRBS, C_BRBC, C_LPM} iclass_e;
  typedef struct packed {
    logic [15:0] mask;
    logic [15:0] value;
  } op_match_t;
  localparam op_match_t OP_RJMP   = '{16'hF000, 16'hC000};
  localparam op_match_t OP_RCALL  = '{16'hF000, 16'hD000};
  localparam op_match_t OP_RET    = '{16'hFFFF, 16'h9508};
  localparam op_match_t OP_BRBX   = '{16'hF800, 16'hF000};
  localparam op_match_t OP_LPM_R0 = '{16'hFFFF, 16'h95C8};
  localparam op_match_t OP_LPM_Z  = '{16'hFE0F, 16'h9004};
  localparam op_match_t OP_LPM_ZP = '{16'hFE0F, 16'h9005};
  localparam int K12_W = 12;
  localparam int K7_W  = 7;
  function automatic logic op_is(input logic [15:0] op, input op_match_t m);
    return (op & m.mask) == m.value;
  endfunction
endpackage

// File: rtl/avr_cpu_flow_if.sv
// avr_cpu_flow_if: control bundle between the flow sequencer (master) and the fetch unit (slave)
interface avr_cpu_flow_if #(parameter int PC_WIDTH = 16);
  logic [15:0]         opcode;
  logic [7:0]          sreg;
  logic [15:0]         z_addr;
  logic [7:0]          lpm_data;
  logic [PC_WIDTH-1:0] pc_update;
  logic                hold;
  logic                write_stack;
  logic                read_stack;
  logic                lpm_read;
  logic [PC_WIDTH-1:0] lpm_addr;
  logic                reg_wr_en;
  logic [4:0]          reg_wr_addr;
  logic [7:0]          reg_wr_data;
  logic                z_inc;
  logic                busy;
  modport master(
    input  opcode, sreg, z_addr, lpm_data,
    output pc_update, hold, write_stack, read_stack, lpm_read, lpm_addr,
           reg_wr_en, reg_wr_addr, reg_wr_data, z_inc, busy
  );
  modport slave(
    output opcode, sreg, z_addr, lpm_data,
    input  pc_update, hold, write_stack, read_stack, lpm_read, lpm_addr,
           reg_wr_en, reg_wr_addr, reg_wr_data, z_inc, busy
  );
endinterface

// File: rtl/avr_cpu_flow_decode.sv
// avr_cpu_flow_decode: combinational classifier giving class, sign-extended offset, Rd, SREG bit and Z+ flag
module avr_cpu_flow_decode
  import avr_cpu_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic [15:0]         opcode,
  output iclass_e             iclass,
  output logic [PC_WIDTH-1:0] offset,
  output logic [4:0]          rd,
  output logic [2:0]          bsel,
  output logic                zp
);
  logic [PC_WIDTH-1:0] k12;
  logic [PC_WIDTH-1:0] k7;
  logic                brb;
  assign k12 = {{(PC_WIDTH-K12_W){opcode[11]}}, opcode[11:0]};
  assign k7  = {{(PC_WIDTH-K7_W){opcode[9]}}, opcode[9:3]};
  assign brb = op_is(opcode, OP_BRBX);
  always_comb begin
    iclass = op_is(opcode, OP_RJMP)  ? C_RJMP  :
             op_is(opcode, OP_RCALL) ? C_RCALL :
             op_is(opcode, OP_RET)   ? C_RET   :
             brb                     ? (opcode[10] ? C_BRBC : C_BRBS) :
             (op_is(opcode, OP_LPM_R0) || op_is(opcode, OP_LPM_Z) || op_is(opcode, OP_LPM_ZP)) ? C_LPM :
             C_NONE;
    offset = brb ? k7 : k12;
    rd     = op_is(opcode, OP_LPM_R0) ? 5'd0 : opcode[8:4];
    bsel   = opcode[2:0];
    zp     = op_is(opcode, OP_LPM_ZP);
  end
endmodule

// File: rtl/avr_cpu_flow.sv
// avr_cpu_flow: control-flow sequencer driving fetch (jumps, calls, returns, branches, LPM)
module avr_cpu_flow
  import avr_cpu_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int LPM_LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  avr_cpu_flow_if.master bus
);
  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [4:0]          rd_q, rd_d;
  logic                zp_q, zp_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  iclass_e             iclass;
  logic [PC_WIDTH-1:0] offset;
  logic [4:0]          rd;
  logic [2:0]          bsel;
  logic                zp;
  logic                taken;
  avr_cpu_flow_decode #(.PC_WIDTH(PC_WIDTH)) u_decode (
    .opcode(bus.opcode),
    .iclass(iclass),
    .offset(offset),
    .rd(rd),
    .bsel(bsel),
    .zp(zp)
  );
  assign taken = bus.sreg[bsel] ^ (iclass == C_BRBC);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EXEC;
      cnt_q   <= '0;
      rd_q    <= '0;
      zp_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      zp_q    <= zp_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    zp_d    = zp_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bus.pc_update   = '0;
    bus.hold        = 1'b0;
    bus.write_stack = 1'b0;
    bus.read_stack  = 1'b0;
    bus.lpm_read    = 1'b0;
    bus.lpm_addr    = '0;
    bus.reg_wr_en   = 1'b0;
    bus.reg_wr_addr = '0;
    bus.reg_wr_data = '0;
    bus.z_inc       = 1'b0;
    bus.busy        = state_q != S_EXEC;
    case (state_q)
      S_EXEC: begin
        if (iclass == C_RJMP || iclass == C_RCALL || ((iclass == C_BRBS || iclass == C_BRBC) && taken)) begin
          bus.pc_update   = offset;
          bus.hold        = 1'b1;
          bus.write_stack = iclass == C_RCALL;
          state_d         = S_FLUSH;
        end else if (iclass == C_RET) begin
          bus.read_stack = 1'b1;
          bus.hold       = 1'b1;
          state_d        = S_FLUSH;
        end else if (iclass == C_LPM) begin
          bus.lpm_read = 1'b1;
          bus.lpm_addr = PC_WIDTH'(bus.z_addr);
          bus.hold     = 1'b1;
          addr_d       = PC_WIDTH'(bus.z_addr);
          rd_d         = rd;
          zp_d         = zp;
          cnt_d        = 2'(LPM_LATENCY - 1);
          state_d      = S_LPM_WAIT;
        end
      end
      S_FLUSH: state_d = S_EXEC;
      S_LPM_WAIT: begin
        bus.hold     = 1'b1;
        bus.lpm_addr = addr_q;
        cnt_d        = cnt_q != 2'd0 ? cnt_q - 2'd1 : cnt_q;
        data_d       = cnt_q == 2'd0 ? bus.lpm_data : data_q;
        state_d      = cnt_q == 2'd0 ? S_LPM_WB : S_LPM_WAIT;
      end
      S_LPM_WB: begin
        bus.reg_wr_en   = 1'b1;
        bus.reg_wr_addr = rd_q;
        bus.reg_wr_data = data_q;
        bus.z_inc       = zp_q;
        state_d         = S_EXEC;
      end
      default: state_d = S_EXEC;
    endcase
    // reset masks every strobe so an aborted instruction leaves no trace
    if (!rst) begin
      bus.pc_update   = '0;
      bus.hold        = 1'b0;
      bus.write_stack = 1'b0;
      bus.read_stack  = 1'b0;
      bus.lpm_read    = 1'b0;
      bus.lpm_addr    = '0;
      bus.reg_wr_en   = 1'b0;
      bus.reg_wr_addr = '0;
      bus.reg_wr_data = '0;
      bus.z_inc       = 1'b0;
      bus.busy        = 1'b0;
    end
  end
endmodule

// File: tb/tb_avr_cpu_flow.sv
// tb_avr_cpu_flow: directed cycle table plus random instruction stream checked against a per-instruction cycle model
module tb_avr_cpu_flow;
  localparam int L = 1;
  typedef struct packed {
    logic [15:0] pc;
    logic        hold, ws, rs, lr;
    logic [15:0] la;
    logic        we;
    logic [4:0]  wa;
    logic [7:0]  wd;
    logic        zi, busy;
  } out_t;
  typedef struct {
    logic        rst;
    logic [15:0] op;
    logic [7:0]  sr;
    logic [15:0] z;
    logic [7:0]  ld;
    out_t        e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nmis = 0;
  out_t act;
  out_t eq[$];
  logic [7:0] dq[$];
  vec_t tbl[$];
  avr_cpu_flow_if #(.PC_WIDTH(16)) bus ();
  avr_cpu_flow #(.PC_WIDTH(16), .LPM_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign act = {bus.pc_update, bus.hold, bus.write_stack, bus.read_stack, bus.lpm_read, bus.lpm_addr,
                bus.reg_wr_en, bus.reg_wr_addr, bus.reg_wr_data, bus.z_inc, bus.busy};
  function automatic out_t o(input logic [15:0] pc, input logic h, ws, rs, lr, input logic [15:0] la,
                             input logic we, input logic [4:0] wa, input logic [7:0] wd, input logic zi, b);
    return {pc, h, ws, rs, lr, la, we, wa, wd, zi, b};
  endfunction
  task automatic add(input logic r, input logic [15:0] op, input logic [7:0] sr, input logic [15:0] z,
                     input logic [7:0] ld, input out_t e);
    vec_t v;
    v.rst = r; v.op = op; v.sr = sr; v.z = z; v.ld = ld; v.e = e;
    tbl.push_back(v);
  endtask
  task automatic drive(input logic r, input logic [15:0] op, input logic [7:0] sr, input logic [15:0] z, input logic [7:0] ld);
    rst = r; bus.opcode = op; bus.sreg = sr; bus.z_addr = z; bus.lpm_data = ld;
  endtask
  task automatic check(input string name, input int idx, input out_t e);
    nvec++;
    if (act !== e) begin
      nmis++;
      $display("FAIL %s[%0d]: got pc=%h hold=%b ws=%b rs=%b lr=%b la=%h we=%b wa=%0d wd=%h zi=%b busy=%b, want pc=%h hold=%b ws=%b rs=%b lr=%b la=%h we=%b wa=%0d wd=%h zi=%b busy=%b",
               name, idx, act.pc, act.hold, act.ws, act.rs, act.lr, act.la, act.we, act.wa, act.wd, act.zi, act.busy,
               e.pc, e.hold, e.ws, e.rs, e.lr, e.la, e.we, e.wa, e.wd, e.zi, e.busy);
    end
  endtask
  task automatic put(input out_t r, input logic [7:0] d);
    eq.push_back(r);
    dq.push_back(d);
  endtask
  // model: expand one instruction issued in EXEC into its full per-cycle output trace
  task automatic issue(input logic [15:0] op, input logic [7:0] sr, input logic [15:0] z);
    out_t r, fl;
    int k;
    logic [7:0] da[$];
    r = '0;
    fl = '0;
    fl.busy = 1'b1;
    if (op[15:13] == 3'b110) begin
      k = int'(op[11:0]);
      if (k >= 2048) k -= 4096;
      r.pc = 16'(k); r.hold = 1'b1; r.ws = op[12];
      put(r, 8'($urandom)); put(fl, 8'($urandom));
    end else if (op == 16'h9508) begin
      r.rs = 1'b1; r.hold = 1'b1;
      put(r, 8'($urandom)); put(fl, 8'($urandom));
    end else if (op[15:11] == 5'b11110 && sr[op[2:0]] == !op[10]) begin
      k = int'(op[9:3]);
      if (k >= 64) k -= 128;
      r.pc = 16'(k); r.hold = 1'b1;
      put(r, 8'($urandom)); put(fl, 8'($urandom));
    end else if (op == 16'h95C8 || (op[15:9] == 7'b1001000 && (op[3:0] == 4'h4 || op[3:0] == 4'h5))) begin
      for (int i = 0; i <= L + 1; i++) da.push_back(8'($urandom));
      r.lr = 1'b1; r.la = z; r.hold = 1'b1;
      put(r, da[0]);
      for (int i = 1; i <= L; i++) put(o(16'h0, 1, 0, 0, 0, z, 0, 5'd0, 8'h00, 0, 1), da[i]);
      put(o(16'h0, 0, 0, 0, 0, 16'h0, 1, op == 16'h95C8 ? 5'd0 : op[8:4], da[L], op != 16'h95C8 && op[0], 1), da[L+1]);
    end else begin
      put(r, 8'($urandom));
    end
  endtask
  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 7))
      0: return {4'hC, 12'($urandom)};
      1: return {4'hD, 12'($urandom)};
      2: return 16'h9508;
      3: return {5'b11110, 11'($urandom)};
      4: return 16'h95C8;
      5: return {7'b1001000, 5'($urandom), 4'h4};
      6: return {7'b1001000, 5'($urandom), 4'h5};
      default: return 16'($urandom);
    endcase
  endfunction
  initial begin
    logic [15:0] op, z;
    logic [7:0] sr, ld;
    out_t e;
    add(0, 16'hC004, 8'h00, 16'h0000, 8'h00, '0);
    add(1, 16'hC004, 8'h00, 16'h0000, 8'h00, o(16'h0004, 1, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 0));
    add(1, 16'hC004, 8'h00, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 1));
    add(1, 16'hDFFF, 8'h00, 16'h0000, 8'h00, o(16'hFFFF, 1, 1, 0, 0, 16'h0, 0, 0, 8'h0, 0, 0));
    add(1, 16'h9508, 8'h00, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 1));
    add(1, 16'h9508, 8'h00, 16'h0000, 8'h00, o(16'h0000, 1, 0, 1, 0, 16'h0, 0, 0, 8'h0, 0, 0));
    add(1, 16'h0000, 8'h00, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 1));
    add(1, 16'hF011, 8'h02, 16'h0000, 8'h00, o(16'h0002, 1, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 0));
    add(1, 16'h0000, 8'h00, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 1));
    add(1, 16'hF011, 8'h00, 16'h0000, 8'h00, '0);
    add(1, 16'hF7F9, 8'h00, 16'h0000, 8'h00, o(16'hFFFF, 1, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 0));
    add(1, 16'h0000, 8'h00, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 1));
    add(1, 16'h9055, 8'h00, 16'h0123, 8'h00, o(16'h0000, 1, 0, 0, 1, 16'h0123, 0, 0, 8'h0, 0, 0));
    add(1, 16'h0000, 8'h00, 16'h0456, 8'hA5, o(16'h0000, 1, 0, 0, 0, 16'h0123, 0, 0, 8'h0, 0, 1));
    add(1, 16'h0000, 8'h00, 16'h0456, 8'h3C, o(16'h0000, 0, 0, 0, 0, 16'h0, 1, 5, 8'hA5, 1, 1));
    add(1, 16'h95C8, 8'h00, 16'h0200, 8'h00, o(16'h0000, 1, 0, 0, 1, 16'h0200, 0, 0, 8'h0, 0, 0));
    add(1, 16'hC004, 8'h00, 16'h0000, 8'h77, o(16'h0000, 1, 0, 0, 0, 16'h0200, 0, 0, 8'h0, 0, 1));
    add(1, 16'h9508, 8'h00, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 1, 0, 8'h77, 0, 1));
    add(1, 16'h9054, 8'h00, 16'h0300, 8'h00, o(16'h0000, 1, 0, 0, 1, 16'h0300, 0, 0, 8'h0, 0, 0));
    add(0, 16'h0000, 8'h00, 16'h0000, 8'h11, '0);
    add(1, 16'h0000, 8'h00, 16'h0000, 8'h00, '0);
    add(1, 16'h0000, 8'h00, 16'h0000, 8'h00, '0);
    add(1, 16'hC800, 8'h00, 16'h0000, 8'h00, o(16'hF800, 1, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 0));
    add(1, 16'hF017, 8'h80, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 1));
    add(1, 16'hF017, 8'h80, 16'h0000, 8'h00, o(16'h0002, 1, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 0));
    add(1, 16'h0000, 8'h00, 16'h0000, 8'h00, o(16'h0000, 0, 0, 0, 0, 16'h0, 0, 0, 8'h0, 0, 1));
    drive(0, 16'h0, 8'h0, 16'h0, 8'h0);
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].rst, tbl[i].op, tbl[i].sr, tbl[i].z, tbl[i].ld);
      @(negedge clk);
      check("table", i, tbl[i].e);
    end
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      sr = 8'($urandom);
      z  = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        eq.delete();
        dq.delete();
        drive(0, 16'($urandom), sr, z, 8'($urandom));
        e = '0;
      end else begin
        if (eq.size() == 0) begin
          op = pick_op();
          issue(op, sr, z);
        end else begin
          op = ($urandom_range(0, 1) == 0) ? pick_op() : 16'($urandom);
        end
        e  = eq.pop_front();
        ld = dq.pop_front();
        drive(1, op, sr, z, ld);
      end
      @(negedge clk);
      check("random", c, e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
